// File: rtl/nco_pkg.sv
// Shared definitions for the multi-channel quarter-wave NCO: channel-width
// helper, config-select encodings, quadrant mapping and the sine table values.
package nco_pkg;

   localparam logic CFG_SEL_INC = 1'b0;
   localparam logic CFG_SEL_OFF = 1'b1;

   typedef struct packed {
      logic mirror;  // read the quarter wave backwards (~a)
      logic neg;     // negate the table value
   } qw_map_t;

   function automatic int chw_of(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Peak table amplitude; keeps +/- symmetric so -2^(MPR-1) never appears.
   function automatic int qw_amp(input int mpr);
      return (1 << (mpr - 1)) - 1;
   endfunction

   function automatic qw_map_t qw_map(input logic [1:0] q);
      qw_map_t m;
      m.mirror = q[0];
      m.neg    = q[1];
      return m;
   endfunction

   // round(amp * sin((k+0.5)*pi/2^(romaw+1))) in Q60 fixed point so the table
   // is computed at elaboration with integer arithmetic only.
   function automatic int qw_sin(input int k, input int romaw, input int mpr);
      logic signed [127:0] pi60, x, x2, term, sum, val;
      pi60 = 128'sh3243F6A8885A308D;
      x    = (128'(2 * k + 1) * pi60) >>> (romaw + 2);
      x2   = (x * x) >>> 60;
      term = x;
      sum  = x;
      for (int i = 1; i <= 12; i++) begin
         term = -((term * x2) >>> 60) / 128'(2 * i * (2 * i + 1));
         sum  = sum + term;
      end
      val = (sum * 128'(qw_amp(mpr)) + (128'sd1 <<< 59)) >>> 60;
      return int'(val[31:0]);
   endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Dual-read quarter-wave sine ROM with registered, clken-gated outputs.
module nco_qw_rom
   import nco_pkg::*;
#(
   parameter int ROMAW    = 10,
   parameter int MPR      = 16,
   parameter     ROM_FILE = "nco_qw_rom.hex"
) (
   input  logic             clk_i,
   input  logic             clken_i,
   input  logic [ROMAW-1:0] addr_a_i,
   input  logic [ROMAW-1:0] addr_b_i,
   output logic [MPR-2:0]   data_a_o,
   output logic [MPR-2:0]   data_b_o
);

   localparam int DW    = MPR - 1;
   localparam int DEPTH = 1 << ROMAW;

   logic [DW-1:0] rom_w [DEPTH];

   // Table contents are generated in place, so ROM_FILE is only kept for
   // drop-in compatibility with the file-initialised variant.
   if ($bits(ROM_FILE) == 0) begin : g_no_rom_file
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_tbl
      localparam int V = qw_sin(k, ROMAW, MPR);
      assign rom_w[k] = DW'(V);
   end

   // Registered read on both ports; frozen with the rest of the pipeline.
   always_ff @(posedge clk_i) begin
      if (clken_i) begin
         data_a_o <= rom_w[addr_a_i];
         data_b_o <= rom_w[addr_b_i];
      end
   end

endmodule

// File: rtl/nco_mc_qw.sv
// Time-multiplexed multi-channel NCO: per-channel accumulator, increment and
// phase offset, round-robin slots, phase-sync round, quarter-wave sin/cos out.
module nco_mc_qw
   import nco_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int APR      = 32,
   parameter int MPR      = 16,
   parameter int ROMAW    = 10,
   parameter     ROM_FILE = "nco_qw_rom.hex",
   localparam int CHW     = chw_of(NCH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clken,
   input  logic                  cfg_we,
   input  logic [CHW-1:0]        cfg_ch,
   input  logic                  cfg_sel,
   input  logic [APR-1:0]        cfg_data,
   input  logic                  cfg_sync,
   output logic signed [MPR-1:0] fsin_o,
   output logic signed [MPR-1:0] fcos_o,
   output logic [CHW-1:0]        out_ch,
   output logic                  out_valid
);

   function automatic logic signed [MPR-1:0] cond_neg(input logic [MPR-2:0] mag,
                                                      input logic neg);
      logic signed [MPR-1:0] v;
      v = signed'({1'b0, mag});
      return neg ? -v : v;
   endfunction

   logic [CHW-1:0]   ch_cnt_q;
   logic [APR-1:0]   acc_q [NCH];
   logic [APR-1:0]   inc_q [NCH];
   logic [APR-1:0]   off_q [NCH];
   logic             sync_pend_q, sync_arm_q;

   logic             first_slot, last_slot, zero_acc;
   logic [APR-1:0]   acc_p0, phase_p0, acc_d;
   logic [ROMAW+1:0] ptop_p0;
   logic             unused_phase_lsb;

   logic [ROMAW+1:0] ptop_p1_q;
   logic [CHW-1:0]   ch_p1_q, ch_p2_q;
   logic             vld_p1_q, vld_p2_q;
   logic             neg_sin_p2_q, neg_cos_p2_q;
   logic [MPR-2:0]   rom_sin_p2, rom_cos_p2;

   qw_map_t          sin_m, cos_m;
   logic [1:0]       quad_p1;
   logic [ROMAW-1:0] a_p1, addr_sin_p1, addr_cos_p1;

   // S0: slot phase from the pre-increment (or sync-zeroed) accumulator
   always_comb begin
      first_slot = (ch_cnt_q == '0);
      last_slot  = (ch_cnt_q == CHW'(NCH - 1));
      zero_acc   = sync_arm_q | (first_slot & sync_pend_q);
      acc_p0     = zero_acc ? '0 : acc_q[ch_cnt_q];
      phase_p0   = acc_p0 + off_q[ch_cnt_q];
      acc_d      = acc_p0 + inc_q[ch_cnt_q];
      ptop_p0    = phase_p0[APR-1 -: ROMAW+2];
   end

   assign unused_phase_lsb = ^phase_p0[APR-ROMAW-3:0];

   // Control state: slot counter, register banks, sync round, S0->S2 valids
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ch_cnt_q    <= '0;
         sync_pend_q <= 1'b0;
         sync_arm_q  <= 1'b0;
         vld_p1_q    <= 1'b0;
         vld_p2_q    <= 1'b0;
         ch_p1_q     <= '0;
         ch_p2_q     <= '0;
         for (int i = 0; i < NCH; i++) begin
            acc_q[i] <= '0;
            inc_q[i] <= '0;
            off_q[i] <= '0;
         end
      end else begin
         // Shadow writes land regardless of clken; the slot read above sees
         // the value from before this edge.
         for (int i = 0; i < NCH; i++) begin
            if (cfg_we && cfg_ch == CHW'(i)) begin
               if (cfg_sel == CFG_SEL_OFF) off_q[i] <= cfg_data;
               else                        inc_q[i] <= cfg_data;
            end
         end
         if (clken) begin
            acc_q[ch_cnt_q] <= acc_d;
            ch_cnt_q        <= last_slot ? '0 : ch_cnt_q + 1'b1;
            vld_p1_q        <= 1'b1;
            ch_p1_q         <= ch_cnt_q;
            vld_p2_q        <= vld_p1_q;
            ch_p2_q         <= ch_p1_q;
         end
         if (clken && last_slot && zero_acc) begin
            sync_pend_q <= 1'b0;
            sync_arm_q  <= 1'b0;
         end else begin
            if (clken && first_slot && sync_pend_q) sync_arm_q <= 1'b1;
            if (cfg_sync && !sync_arm_q)            sync_pend_q <= 1'b1;
         end
      end
   end

   // S0 -> S1: keep only the phase bits that address the table
   always_ff @(posedge clk) begin
      if (clken) ptop_p1_q <= ptop_p0;
   end

   // S1: quadrant mapping; cosine is the sine one quadrant ahead
   always_comb begin
      quad_p1     = ptop_p1_q[ROMAW+1:ROMAW];
      a_p1        = ptop_p1_q[ROMAW-1:0];
      sin_m       = qw_map(quad_p1);
      cos_m       = qw_map(quad_p1 + 2'd1);
      addr_sin_p1 = sin_m.mirror ? ~a_p1 : a_p1;
      addr_cos_p1 = cos_m.mirror ? ~a_p1 : a_p1;
   end

   // S1 -> S2: negate flags travel alongside the ROM read
   always_ff @(posedge clk) begin
      if (clken) begin
         neg_sin_p2_q <= sin_m.neg;
         neg_cos_p2_q <= cos_m.neg;
      end
   end

   nco_qw_rom #(
      .ROMAW    (ROMAW),
      .MPR      (MPR),
      .ROM_FILE (ROM_FILE)
   ) u_rom (
      .clk_i    (clk),
      .clken_i  (clken),
      .addr_a_i (addr_sin_p1),
      .addr_b_i (addr_cos_p1),
      .data_a_o (rom_sin_p2),
      .data_b_o (rom_cos_p2)
   );

   // S2 -> S3: sign restore and output register; data only loads when valid
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fsin_o    <= '0;
         fcos_o    <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
      end else if (clken) begin
         out_valid <= vld_p2_q;
         if (vld_p2_q) begin
            fsin_o <= cond_neg(rom_sin_p2, neg_sin_p2_q);
            fcos_o <= cond_neg(rom_cos_p2, neg_cos_p2_q);
            out_ch <= ch_p2_q;
         end
      end
   end

endmodule

// File: tb/tb_nco_mc_qw.sv
// Self-checking bench for nco_mc_qw (NCH=4, APR=32, MPR=16, ROMAW=8).
module tb_nco_mc_qw;

   localparam int  NCH   = 4;
   localparam int  APR   = 32;
   localparam int  MPR   = 16;
   localparam int  ROMAW = 8;
   localparam int  CHW   = 2;
   localparam int  AMP   = 32767;
   localparam real PI    = 3.14159265358979323846;

   logic                  clk = 1'b0;
   logic                  reset_n, clken, cfg_we, cfg_sel, cfg_sync;
   logic [CHW-1:0]        cfg_ch;
   logic [APR-1:0]        cfg_data;
   logic signed [MPR-1:0] fsin_o, fcos_o;
   logic [CHW-1:0]        out_ch;
   logic                  out_valid;

   int total = 0;
   int bad   = 0;

   nco_mc_qw #(
      .NCH   (NCH),
      .APR   (APR),
      .MPR   (MPR),
      .ROMAW (ROMAW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clken     (clken),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_sel   (cfg_sel),
      .cfg_data  (cfg_data),
      .cfg_sync  (cfg_sync),
      .fsin_o    (fsin_o),
      .fcos_o    (fcos_o),
      .out_ch    (out_ch),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int rnd_away(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
   endfunction

   function automatic real ph_angle(input logic [APR-1:0] ph);
      int p;
      p = int'(ph[APR-1 -: ROMAW+2]);
      return (real'(p) + 0.5) * 2.0 * PI / (2.0 ** (ROMAW + 2));
   endfunction

   function automatic int model_sin(input logic [APR-1:0] ph);
      return rnd_away(real'(AMP) * $sin(ph_angle(ph)));
   endfunction

   function automatic int model_cos(input logic [APR-1:0] ph);
      return rnd_away(real'(AMP) * $cos(ph_angle(ph)));
   endfunction

   typedef struct { int ch; int s; int c; } samp_t;

   logic [APR-1:0] m_acc [NCH];
   logic [APR-1:0] m_inc [NCH];
   logic [APR-1:0] m_off [NCH];
   int    m_slot = 0;
   bit    m_pend = 0, m_zero_round = 0;
   samp_t m_pipe [$];
   int    e_sin = 0, e_cos = 0, e_ch = 0;
   bit    e_vld = 0;
   bit    chk_en = 0;

   always @(posedge clk) begin : model
      bit             armed;
      int             c;
      logic [APR-1:0] a, ph;
      samp_t          s;
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            m_acc[i] = '0; m_inc[i] = '0; m_off[i] = '0;
         end
         m_slot = 0; m_pend = 0; m_zero_round = 0;
         m_pipe.delete();
         e_sin = 0; e_cos = 0; e_ch = 0; e_vld = 0;
      end else begin
         armed = m_zero_round;
         if (clken) begin
            c = m_slot;
            if (c == 0 && m_pend) m_zero_round = 1;
            armed = m_zero_round;
            a  = m_zero_round ? '0 : m_acc[c];
            ph = a + m_off[c];
            m_acc[c] = a + m_inc[c];
            m_pipe.push_back('{c, model_sin(ph), model_cos(ph)});
            if (m_pipe.size() > 2) begin
               s = m_pipe.pop_front();
               e_ch = s.ch; e_sin = s.s; e_cos = s.c; e_vld = 1;
            end
            if (c == NCH - 1 && m_zero_round) begin
               m_zero_round = 0;
               m_pend = 0;
            end
            m_slot = (c + 1) % NCH;
         end
         if (cfg_sync && !armed) m_pend = 1;
         if (cfg_we && int'(cfg_ch) < NCH) begin
            if (cfg_sel) m_off[cfg_ch] = cfg_data;
            else         m_inc[cfg_ch] = cfg_data;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", int'(out_valid), int'(e_vld));
         check("out_ch",    int'(out_ch),    e_ch);
         check("fsin_o",    int'(fsin_o),    e_sin);
         check("fcos_o",    int'(fcos_o),    e_cos);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cfg_write(input int ch, input logic sel, input logic [APR-1:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_sel = sel; cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic wait_out(input int ch, input int budget);
      bit found;
      found = 0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (out_valid && int'(out_ch) == ch) found = 1;
      end
      check("wait_out_ch", int'(found), 1);
   endtask

   initial begin
      reset_n = 1'b0; clken = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0;
      cfg_ch = '0; cfg_data = '0; cfg_sync = 1'b0;

      // pin the model to hand-computed table values
      check("mdl_sin_0",   model_sin(32'h0000_0000), 101);
      check("mdl_cos_0",   model_cos(32'h0000_0000), 32767);
      check("mdl_sin_90",  model_sin(32'h4000_0000), 32767);
      check("mdl_cos_90",  model_cos(32'h4000_0000), -101);
      check("mdl_sin_180", model_sin(32'h8000_0000), -101);
      check("mdl_sin_270", model_sin(32'hC000_0000), -32767);

      repeat (2) @(negedge clk);
      chk_en = 1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_fsin",  int'(fsin_o), 0);
      check("rst_ch",    int'(out_ch), 0);
      reset_n = 1'b1;

      // warm-up: valid after exactly 3 clken cycles, ch0 first
      @(negedge clk);
      @(negedge clk);
      check("warm2_valid", int'(out_valid), 0);
      @(negedge clk);
      check("warm3_valid", int'(out_valid), 1);
      check("warm3_ch",    int'(out_ch), 0);
      check("zero_fsin",   int'(fsin_o), 101);
      check("zero_fcos",   int'(fcos_o), 32767);
      @(negedge clk);
      check("order_ch1",   int'(out_ch), 1);
      repeat (8) @(negedge clk);

      // ch1 90-degree offset
      cfg_write(1, 1'b1, 32'h4000_0000);
      repeat (10) @(negedge clk);
      wait_out(1, 8);
      check("off90_fsin", int'(fsin_o), 32767);
      check("off90_fcos", int'(fcos_o), -101);

      // ch2 quarter-turn increment, several wraps
      cfg_write(2, 1'b0, 32'h4000_0000);
      repeat (40) @(negedge clk);

      // increment write in the same cycle as the ch0 slot
      for (int i = 0; i < 8 && m_slot != 0; i++) @(negedge clk);
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 1'b0; cfg_data = 32'h1234_5678;
      @(negedge clk);
      cfg_we = 1'b0;
      repeat (20) @(negedge clk);

      // sync mid-round with nonzero increments and ch0 offset 0
      cfg_write(1, 1'b0, 32'h0765_4321);
      cfg_write(3, 1'b0, 32'h2222_2222);
      repeat (12) @(negedge clk);
      for (int i = 0; i < 8 && m_slot != 2; i++) @(negedge clk);
      cfg_sync = 1'b1;
      @(negedge clk);
      cfg_sync = 1'b0;
      wait_out(0, 8);
      check("sync_fsin", int'(fsin_o), 101);
      check("sync_fcos", int'(fcos_o), 32767);
      repeat (16) @(negedge clk);

      // clken 1-0-0-1 then a one-cycle reset mid-stream
      clken = 1'b1; @(negedge clk);
      clken = 1'b0; @(negedge clk);
      @(negedge clk);
      clken = 1'b1; @(negedge clk);
      reset_n = 1'b0; @(negedge clk);
      reset_n = 1'b1;
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_fsin",  int'(fsin_o), 0);
      check("mid_rst_fcos",  int'(fcos_o), 0);
      @(negedge clk);
      @(negedge clk);
      check("mid_warm2_valid", int'(out_valid), 0);
      @(negedge clk);
      check("mid_warm3_valid", int'(out_valid), 1);
      check("mid_warm3_fsin",  int'(fsin_o), 101);
      repeat (8) @(negedge clk);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         clken    = ($urandom_range(0, 7) != 0);
         cfg_we   = ($urandom_range(0, 3) == 0);
         cfg_ch   = CHW'($urandom_range(0, NCH - 1));
         cfg_sel  = 1'($urandom_range(0, 1));
         cfg_data = $urandom;
         cfg_sync = ($urandom_range(0, 49) == 0);
         reset_n  = ($urandom_range(0, 499) != 0);
      end
      @(negedge clk);
      reset_n = 1'b1; clken = 1'b1; cfg_we = 1'b0; cfg_sync = 1'b0;
      repeat (8) @(negedge clk);
      chk_en = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
